// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer.
package console_pkg;

  typedef enum logic [1:0] {
    CLR_SCREEN,
    IDLE,
    WR_CHAR,
    CLR_LINE
  } state_t;

  localparam logic [7:0]  CH_CR      = 8'h0D;
  localparam logic [7:0]  CH_LF      = 8'h0A;
  localparam logic [7:0]  CH_BS      = 8'h08;
  localparam logic [7:0]  CH_FF      = 8'h0C;
  localparam logic [31:0] BLANK_WORD = 32'h20202020;

endpackage

// File: rtl/text_console_writer.sv
// Character-stream front end: turns accepted bytes into byte-masked screenbuffer
// writes at a hardware cursor, with CR/LF/BS/FF handling, wrap and line blanking.
module text_console_writer
  import console_pkg::*;
#(
  parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h8000,
  parameter int          COLS                   = 80,
  parameter int          ROWS                   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        wen,
  input  logic        ready,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int CELLS        = ROWS * COLS;
  localparam int IDX_W        = $clog2(CELLS);
  localparam int SCREEN_WORDS = CELLS / 4;
  localparam int LINE_WORDS   = COLS / 4;
  localparam int CNT_W        = $clog2(SCREEN_WORDS);

  state_t            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              wen_q, wen_d;

  logic [4:0]        next_row;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt_inc;

  function automatic logic [31:0] screen_addr(input logic [CNT_W-1:0] k);
    return SCREENBUFFER_BASE_ADDR + (32'(k) << 2);
  endfunction

  function automatic logic [31:0] line_addr(input logic [4:0] row, input logic [CNT_W-1:0] k);
    return SCREENBUFFER_BASE_ADDR + 32'(row) * 32'(COLS) + (32'(k) << 2);
  endfunction

  function automatic logic [31:0] char_addr(input logic [IDX_W-1:0] i);
    return SCREENBUFFER_BASE_ADDR + 32'({i[IDX_W-1:2], 2'b00});
  endfunction

  assign next_row   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
  assign idx        = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign cnt_inc    = cnt_q + 1'b1;

  assign char_ready = (state_q == IDLE);
  assign busy       = ~char_ready;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign wmask      = wmask_q;
  assign wen        = wen_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // State, cursor and bus registers; reset abandons any write and restarts the full clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_SCREEN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
    end
  end

  // Next-state decode; the next bus word is loaded on the transition edge so wen rises one cycle later.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    case (state_q)
      CLR_SCREEN: begin
        if (!wen_q) begin
          wen_d   = 1'b1;
          addr_d  = screen_addr(cnt_q);
          wdata_d = BLANK_WORD;
          wmask_d = 4'hF;
        end else if (ready) begin
          if (cnt_q == CNT_W'(SCREEN_WORDS - 1)) begin
            wen_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_inc;
            addr_d = screen_addr(cnt_inc);
          end
        end
      end
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            CH_CR: col_d = '0;
            CH_LF: begin
              col_d   = '0;
              row_d   = next_row;
              state_d = CLR_LINE;
              cnt_d   = '0;
              addr_d  = line_addr(next_row, '0);
              wdata_d = BLANK_WORD;
              wmask_d = 4'hF;
              wen_d   = 1'b1;
            end
            CH_BS: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            CH_FF: begin
              col_d   = '0;
              row_d   = '0;
              state_d = CLR_SCREEN;
              cnt_d   = '0;
              addr_d  = screen_addr('0);
              wdata_d = BLANK_WORD;
              wmask_d = 4'hF;
              wen_d   = 1'b1;
            end
            default: begin
              state_d = WR_CHAR;
              addr_d  = char_addr(idx);
              wdata_d = {4{char_data}};
              wmask_d = 4'b0001 << idx[1:0];
              wen_d   = 1'b1;
            end
          endcase
        end
      end
      WR_CHAR: begin
        if (wen_q && ready) begin
          if (col_q < 7'(COLS - 1)) begin
            col_d   = col_q + 7'd1;
            wen_d   = 1'b0;
            state_d = IDLE;
          end else begin
            col_d   = '0;
            row_d   = next_row;
            state_d = CLR_LINE;
            cnt_d   = '0;
            addr_d  = line_addr(next_row, '0);
            wdata_d = BLANK_WORD;
            wmask_d = 4'hF;
          end
        end
      end
      CLR_LINE: begin
        if (wen_q && ready) begin
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            wen_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_inc;
            addr_d = line_addr(row_q, cnt_inc);
          end
        end
      end
      default: state_d = CLR_SCREEN;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: directed vector table plus
// hand-written sequences for clears, wrap, stalls and reset.
module tb_text_console_writer;

  localparam logic [31:0] BASE  = 32'h8000;
  localparam logic [31:0] BLANK = 32'h20202020;

  logic        clk;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ready;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]  ch;
    bit          has_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [4:0]  row;
    logic [6:0]  col;
  } vec_t;

  vec_t vecs [10];

  text_console_writer #(
    .SCREENBUFFER_BASE_ADDR(32'h8000),
    .COLS(80),
    .ROWS(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .addr(addr),
    .wdata(wdata),
    .wmask(wmask),
    .wen(wen),
    .ready(ready),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the design stalls forever.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, failed so far %0d", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one byte (called at a negedge); returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [7:0] ch);
    int n;
    n = 0;
    char_valid = 1'b1;
    char_data  = ch;
    while (!char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: char %h never accepted, char_ready %b", ch, char_ready);
    end
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // Compare one bus word {wen,busy,addr,wdata,wmask}, then let it retire.
  task automatic expect_write(input string name, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input int max_wait);
    int n;
    n = 0;
    while (!wen && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {wen, busy, addr, wdata, wmask}, {1'b1, 1'b1, a, d, m});
    @(negedge clk);
  endtask

  task automatic expect_screen_clear(input int first_wait);
    for (int k = 0; k < 600; k++)
      expect_write($sformatf("clr_screen[%0d]", k), BASE + 32'(4 * k), BLANK, 4'hF,
                   (k == 0) ? first_wait : 0);
  endtask

  task automatic expect_line_clear(input int row);
    for (int k = 0; k < 20; k++)
      expect_write($sformatf("clr_line%0d[%0d]", row, k), BASE + 32'(row * 80 + 4 * k), BLANK,
                   4'hF, 0);
  endtask

  task automatic write_char(input logic [7:0] ch, input int row, input int col);
    int i;
    i = row * 80 + col;
    applyStimulus(ch);
    expect_write($sformatf("char(%0d,%0d)", row, col), BASE + 32'(i - (i % 4)), {4{ch}},
                 4'b0001 << (i % 4), 0);
  endtask

  task automatic check_idle(input string name, input logic [4:0] row, input logic [6:0] col);
    checkOutput(name, {wen, char_ready, cursor_row, cursor_col}, {1'b0, 1'b1, row, col});
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b1, 32'h8000, 32'h41414141, 4'h1, 5'd0, 7'd1};
    vecs[1] = '{8'h42, 1'b1, 32'h8000, 32'h42424242, 4'h2, 5'd0, 7'd2};
    vecs[2] = '{8'h43, 1'b1, 32'h8000, 32'h43434343, 4'h4, 5'd0, 7'd3};
    vecs[3] = '{8'h44, 1'b1, 32'h8000, 32'h44444444, 4'h8, 5'd0, 7'd4};
    vecs[4] = '{8'h45, 1'b1, 32'h8004, 32'h45454545, 4'h1, 5'd0, 7'd5};
    vecs[5] = '{8'h08, 1'b0, 32'h0,    32'h0,        4'h0, 5'd0, 7'd4};
    vecs[6] = '{8'h46, 1'b1, 32'h8004, 32'h46464646, 4'h1, 5'd0, 7'd5};
    vecs[7] = '{8'h0D, 1'b0, 32'h0,    32'h0,        4'h0, 5'd0, 7'd0};
    vecs[8] = '{8'h00, 1'b1, 32'h8000, 32'h00000000, 4'h1, 5'd0, 7'd1};
    vecs[9] = '{8'h07, 1'b1, 32'h8000, 32'h07070707, 4'h2, 5'd0, 7'd2};

    rst        = 1'b1;
    ready      = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state and the full-screen clear after release
    checkOutput("reset_state", {wen, char_ready, busy, cursor_row, cursor_col},
                {1'b0, 1'b0, 1'b1, 5'd0, 7'd0});
    rst = 1'b0;
    expect_screen_clear(3);
    check_idle("after_screen_clear", 5'd0, 7'd0);

    // Table of single-byte vectors from (0,0)
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].ch);
      if (vecs[v].has_write) begin
        expect_write($sformatf("vec%0d_write", v), vecs[v].addr, vecs[v].wdata, vecs[v].wmask, 0);
      end
      check_idle($sformatf("vec%0d_cursor", v), vecs[v].row, vecs[v].col);
    end

    // Move to (3,10) then LF: clears row 4 at 0x8140..0x818C
    applyStimulus(8'h0D);
    check_idle("cr_home", 5'd0, 7'd0);
    for (int r = 1; r <= 3; r++) begin
      applyStimulus(8'h0A);
      expect_line_clear(r);
    end
    for (int c = 0; c < 10; c++) write_char(8'h61 + 8'(c), 3, c);
    check_idle("at_3_10", 5'd3, 7'd10);
    applyStimulus(8'h0A);
    checkOutput("lf_cursor", {busy, cursor_row, cursor_col}, {1'b1, 5'd4, 7'd0});
    expect_line_clear(4);
    check_idle("after_lf", 5'd4, 7'd0);

    // Walk to (29,79) and write the last cell: wraps to row 0 and clears it
    for (int r = 5; r <= 29; r++) begin
      applyStimulus(8'h0A);
      expect_line_clear(r);
    end
    for (int c = 0; c < 79; c++) write_char(8'h7A, 29, c);
    check_idle("at_29_79", 5'd29, 7'd79);
    applyStimulus(8'h5A);
    expect_write("last_cell", 32'h895C, 32'h5A5A5A5A, 4'h8, 0);
    checkOutput("wrap_cursor", {cursor_row, cursor_col}, {5'd0, 7'd0});
    expect_line_clear(0);
    check_idle("after_wrap", 5'd0, 7'd0);

    // Stalled write: ready low for 5 cycles, retires on the 6th
    ready = 1'b0;
    applyStimulus(8'h51);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall_hold[%0d]", i), {wen, char_ready, addr, wdata, wmask},
                  {1'b1, 1'b0, 32'h8000, 32'h51515151, 4'h1});
      @(negedge clk);
    end
    ready = 1'b1;
    checkOutput("stall_hold[5]", {wen, char_ready, addr, wdata, wmask},
                {1'b1, 1'b0, 32'h8000, 32'h51515151, 4'h1});
    @(negedge clk);
    check_idle("stall_retired", 5'd0, 7'd1);

    // Form feed: home cursor and clear the whole screen
    applyStimulus(8'h0C);
    checkOutput("ff_cursor", {busy, cursor_row, cursor_col}, {1'b1, 5'd0, 7'd0});
    expect_screen_clear(0);
    check_idle("after_ff", 5'd0, 7'd0);

    // Reset in the middle of a line clear, then BS at column 0
    write_char(8'h78, 0, 0);
    applyStimulus(8'h0A);
    for (int k = 0; k < 3; k++)
      expect_write($sformatf("pre_reset[%0d]", k), BASE + 32'(80 + 4 * k), BLANK, 4'hF, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset", {wen, char_ready, cursor_row, cursor_col},
                {1'b0, 1'b0, 5'd0, 7'd0});
    rst = 1'b0;
    expect_screen_clear(3);
    check_idle("after_reset_clear", 5'd0, 7'd0);
    applyStimulus(8'h08);
    check_idle("bs_at_col0", 5'd0, 7'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
